// File: rtl/lock_seq_pkg.sv
// Shared definitions for the lock sequencer: FSM state encoding, default
// phase lengths and the counter width helper.
package lock_seq_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_ARRIVE_MAX = 4;
    localparam int unsigned DEF_FANDP_MAX  = 7;
    localparam int unsigned DEF_EVAC_MAX   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARRIVE = 3'd1,
        ST_FANDP  = 3'd2,
        ST_EVAC   = 3'd3,
        ST_DONE   = 3'd4
    } lock_state_e;

    // Truncate a phase limit to counter width; limits must fit in CNT_W bits.
    function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/lock_sequencer_phase_counter.sv
// Phase counter: a saturating 10-bit up-counter with synchronous clear.
// It stops at max_i and flags at_max_o so the sequencer can advance phase.
module phase_counter
    import lock_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] max_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_max_o = (count_q == max_i);
    assign count_o  = count_q;

    // Next count: clear wins, otherwise step by one while below the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !at_max_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// Lock sequencer: steps a canal lock through arrive, fill-and-pump and
// evacuate phases, each timed by ticks of an external timebase.
// Optional feature macro: LOCK_SEQ_ABORT_EN (abort from ARRIVE/FANDP to EVAC).
// Handshake: arrive is a one-cycle request accepted only while busy=0;
// requests seen while busy=1 are dropped. done is a one-cycle pulse.
module lock_sequencer
    import lock_seq_pkg::*;
#(
    parameter int unsigned ARRIVE_MAX = DEF_ARRIVE_MAX,
    parameter int unsigned FANDP_MAX  = DEF_FANDP_MAX,
    parameter int unsigned EVAC_MAX   = DEF_EVAC_MAX
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        tick,
    input  logic        arrive,
    input  logic        abort,
    output logic [9:0]  countArrive,
    output logic [9:0]  countFandP,
    output logic [9:0]  countEvacuate,
    output logic        outerGate,
    output logic        innerGate,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state_o
);

    localparam logic [CNT_W-1:0] ARRIVE_LIM = to_cnt(ARRIVE_MAX);
    localparam logic [CNT_W-1:0] FANDP_LIM  = to_cnt(FANDP_MAX);
    localparam logic [CNT_W-1:0] EVAC_LIM   = to_cnt(EVAC_MAX);

    lock_state_e state_q;
    lock_state_e state_d;

    logic clr_all;
    logic en_arr;
    logic en_fandp;
    logic en_evac;
    logic arr_at_max;
    logic fandp_at_max;
    logic evac_at_max;
    logic abort_req;

    logic outer_q;
    logic inner_q;
    logic busy_q;
    logic done_q;

`ifdef LOCK_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    // The port stays for interface compatibility but drives nothing.
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_req    = 1'b0;
`endif

    // Next state and counter controls; a counter only steps on a tick in its
    // own phase, and the phase changes on the tick that finds it at its limit.
    always_comb begin
        state_d  = state_q;
        clr_all  = 1'b0;
        en_arr   = 1'b0;
        en_fandp = 1'b0;
        en_evac  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arrive) begin
                    state_d = ST_ARRIVE;
                end
            end
            ST_ARRIVE: begin
                if (abort_req) begin
                    state_d = ST_EVAC;
                end else if (tick) begin
                    if (arr_at_max) state_d = ST_FANDP;
                    else            en_arr  = 1'b1;
                end
            end
            ST_FANDP: begin
                if (abort_req) begin
                    state_d = ST_EVAC;
                end else if (tick) begin
                    if (fandp_at_max) state_d  = ST_EVAC;
                    else              en_fandp = 1'b1;
                end
            end
            ST_EVAC: begin
                if (tick) begin
                    if (evac_at_max) state_d = ST_DONE;
                    else             en_evac = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                clr_all = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                clr_all = 1'b1;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            outer_q <= 1'b0;
            inner_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outer_q <= (state_d == ST_ARRIVE);
            inner_q <= (state_d == ST_EVAC);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    phase_counter u_cnt_arrive (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .clear_i  (clr_all),
        .en_i     (en_arr),
        .max_i    (ARRIVE_LIM),
        .count_o  (countArrive),
        .at_max_o (arr_at_max)
    );

    phase_counter u_cnt_fandp (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .clear_i  (clr_all),
        .en_i     (en_fandp),
        .max_i    (FANDP_LIM),
        .count_o  (countFandP),
        .at_max_o (fandp_at_max)
    );

    phase_counter u_cnt_evac (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .clear_i  (clr_all),
        .en_i     (en_evac),
        .max_i    (EVAC_LIM),
        .count_o  (countEvacuate),
        .at_max_o (evac_at_max)
    );

    assign outerGate   = outer_q;
    assign innerGate   = inner_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
